rv32_hazard_ctrl: RTL and testbench

RV32_HAZARD_CTRL -- requirements
Module: rv32_hazard_ctrl

---
 rtl/rv32_hazard_ctrl.sv | 139 +++++++++++++
 tb/tb_rv32_hazard_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_hazard_ctrl.sv
// RV32 pipeline hazard controller: load-use stall, branch flush and
// data-memory wait sequencing, with a saturating stall-cycle counter.
module rv32_hazard_ctrl #(
   parameter int unsigned FLUSH_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   input  logic [4:0]  ex_rd,
   input  logic        ex_load,
   input  logic        branch_taken,
   input  logic        mem_busy,
   output logic        pc_hold,
   output logic        if_id_hold,
   output logic        if_id_flush,
   output logic        id_ex_busy,
   output logic        id_ex_flush,
   output logic [1:0]  state,
   output logic [15:0] stall_cnt
);

   typedef enum logic [1:0] {
      S_RUN        = 2'd0,
      S_LOAD_STALL = 2'd1,
      S_FLUSH      = 2'd2,
      S_MEM_WAIT   = 2'd3
   } state_t;

   localparam logic [3:0] LP_CNT_INIT = 4'(FLUSH_CYCLES - 1);

   state_t      r_state;
   state_t      w_nxt_state;
   logic [3:0]  r_cnt;
   logic [3:0]  w_nxt_cnt;
   logic        r_pend;
   logic        w_nxt_pend;
   logic [15:0] r_stall_cnt;
   logic        w_load_use;

   assign w_load_use = ex_load && (ex_rd != 5'd0) &&
                       ((ex_rd == id_rs1) || (ex_rd == id_rs2));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_FLUSH;
         r_cnt       <= LP_CNT_INIT;
         r_pend      <= 1'b0;
         r_stall_cnt <= 16'd0;
      end else begin
         r_state <= w_nxt_state;
         r_cnt   <= w_nxt_cnt;
         r_pend  <= w_nxt_pend;
         if ((r_state != S_RUN) && (r_stall_cnt != 16'hFFFF))
            r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

   always_comb begin
      w_nxt_state = r_state;
      w_nxt_cnt   = r_cnt;
      w_nxt_pend  = r_pend;
      unique case (r_state)
         S_RUN: begin
            if (branch_taken) begin
               w_nxt_state = S_FLUSH;
               w_nxt_cnt   = LP_CNT_INIT;
            end else if (mem_busy) begin
               w_nxt_state = S_MEM_WAIT;
            end else if (w_load_use) begin
               w_nxt_state = S_LOAD_STALL;
            end
         end
         S_LOAD_STALL: begin
            // single bubble; a still-present load_use must not re-stall
            if (branch_taken) begin
               w_nxt_state = S_FLUSH;
               w_nxt_cnt   = LP_CNT_INIT;
            end else if (mem_busy) begin
               w_nxt_state = S_MEM_WAIT;
            end else begin
               w_nxt_state = S_RUN;
            end
         end
         S_FLUSH: begin
            if (branch_taken) begin
               w_nxt_cnt = LP_CNT_INIT;
            end else if (r_cnt != 4'd0) begin
               w_nxt_cnt = r_cnt - 4'd1;
            end else begin
               w_nxt_state = S_RUN;
            end
         end
         S_MEM_WAIT: begin
            // a redirect seen while frozen is remembered until memory frees
            if (mem_busy) begin
               if (branch_taken) w_nxt_pend = 1'b1;
            end else if (r_pend || branch_taken) begin
               w_nxt_state = S_FLUSH;
               w_nxt_cnt   = LP_CNT_INIT;
               w_nxt_pend  = 1'b0;
            end else begin
               w_nxt_state = S_RUN;
            end
         end
         default: w_nxt_state = S_RUN;
      endcase
   end

   always_comb begin
      pc_hold     = 1'b0;
      if_id_hold  = 1'b0;
      if_id_flush = 1'b0;
      id_ex_busy  = 1'b0;
      id_ex_flush = 1'b0;
      unique case (r_state)
         S_RUN: ;
         S_LOAD_STALL: begin
            pc_hold     = 1'b1;
            if_id_hold  = 1'b1;
            id_ex_flush = 1'b1;
         end
         S_FLUSH: begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
         end
         S_MEM_WAIT: begin
            pc_hold    = 1'b1;
            if_id_hold = 1'b1;
            id_ex_busy = 1'b1;
         end
         default: ;
      endcase
   end

   assign state     = r_state;
   assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_rv32_hazard_ctrl.sv
// Self-checking bench for rv32_hazard_ctrl: directed scenarios plus
// randomized traffic against a behavioural model of the hazard rules.
module tb_rv32_hazard_ctrl;

   localparam int FC  = 2;
   localparam int RUN = 0;
   localparam int LS  = 1;
   localparam int FL  = 2;
   localparam int MW  = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  id_rs1, id_rs2, ex_rd;
   logic        ex_load, branch_taken, mem_busy;
   logic        pc_hold, if_id_hold, if_id_flush, id_ex_busy, id_ex_flush;
   logic [1:0]  state;
   logic [15:0] stall_cnt;

   int n_chk  = 0;
   int n_fail = 0;

   int m_mode;
   int m_rem;
   int m_sc;
   bit m_pend;
   bit seen_ls;

   always #5 clk = ~clk;

   rv32_hazard_ctrl #(.FLUSH_CYCLES(FC)) dut (
      .clk(clk), .rst(rst),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd),
      .ex_load(ex_load), .branch_taken(branch_taken), .mem_busy(mem_busy),
      .pc_hold(pc_hold), .if_id_hold(if_id_hold), .if_id_flush(if_id_flush),
      .id_ex_busy(id_ex_busy), .id_ex_flush(id_ex_flush),
      .state(state), .stall_cnt(stall_cnt)
   );

   wire [4:0] ctl = {pc_hold, if_id_hold, if_id_flush, id_ex_busy, id_ex_flush};

   // control vector {pc_hold,if_id_hold,if_id_flush,id_ex_busy,id_ex_flush}
   function automatic logic [4:0] exp_ctl(int mode);
      case (mode)
         LS:      return 5'b11001;
         FL:      return 5'b00101;
         MW:      return 5'b11010;
         default: return 5'b00000;
      endcase
   endfunction

   // advance one clock; model consumes the inputs sampled at that edge
   task automatic tick();
      bit lu;
      int nm;
      @(posedge clk);
      lu = ex_load && (ex_rd != 0) && (ex_rd == id_rs1 || ex_rd == id_rs2);
      if (rst) begin
         m_mode = FL; m_rem = FC; m_pend = 0; m_sc = 0;
      end else begin
         nm = m_mode;
         if (m_mode != RUN && m_sc < 65535) m_sc++;
         if (m_mode == RUN || m_mode == LS) begin
            if (branch_taken) begin nm = FL; m_rem = FC; end
            else if (mem_busy) nm = MW;
            else if (m_mode == RUN && lu) nm = LS;
            else nm = RUN;
         end else if (m_mode == FL) begin
            if (branch_taken) m_rem = FC;
            else if (m_rem > 1) m_rem--;
            else nm = RUN;
         end else begin
            if (mem_busy) m_pend = m_pend | branch_taken;
            else if (m_pend || branch_taken) begin
               nm = FL; m_rem = FC; m_pend = 0;
            end else nm = RUN;
         end
         m_mode = nm;
      end
      #1;
   endtask

   task automatic idle();
      rst = 0; ex_load = 0; branch_taken = 0; mem_busy = 0;
      id_rs1 = 5'd1; id_rs2 = 5'd2; ex_rd = 5'd3;
   endtask

   task automatic test_reset();
      idle();
      rst = 1;
      tick(); tick();
      n_chk++;
      if (state !== 2'd2 || ctl !== 5'b00101 || stall_cnt !== 16'd0) begin
         n_fail++;
         $display("FAIL reset_vals: state=%0d ctl=%b cnt=%0d want 2 00101 0",
                  state, ctl, stall_cnt);
      end
      rst = 0;
      tick();
      n_chk++;
      if (state !== 2'd2 || ctl !== 5'b00101) begin
         n_fail++;
         $display("FAIL reset_flush1: state=%0d ctl=%b want 2 00101", state, ctl);
      end
      tick();
      n_chk++;
      if (state !== 2'd0 || ctl !== 5'b00000 || stall_cnt !== 16'd2) begin
         n_fail++;
         $display("FAIL reset_to_run: state=%0d ctl=%b cnt=%0d want 0 00000 2",
                  state, ctl, stall_cnt);
      end
   endtask

   task automatic test_load_use();
      idle();
      ex_load = 1; ex_rd = 5'd5; id_rs1 = 5'd7; id_rs2 = 5'd5;
      tick();
      idle();
      n_chk++;
      if (state !== 2'd1 || ctl !== 5'b11001) begin
         n_fail++;
         $display("FAIL load_use_stall: state=%0d ctl=%b want 1 11001", state, ctl);
      end
      tick();
      n_chk++;
      if (state !== 2'd0 || ctl !== 5'b00000) begin
         n_fail++;
         $display("FAIL load_use_exit: state=%0d ctl=%b want 0 00000", state, ctl);
      end
      ex_load = 1; ex_rd = 5'd9; id_rs1 = 5'd9;
      tick(); tick();
      n_chk++;
      if (state !== 2'd0) begin
         n_fail++;
         $display("FAIL load_use_no_repeat: state=%0d want 0", state);
      end
      tick();
      idle();
      n_chk++;
      if (state !== 2'd1) begin
         n_fail++;
         $display("FAIL load_use_again: state=%0d want 1", state);
      end
      tick();
   endtask

   task automatic test_x0();
      idle();
      ex_load = 1; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0;
      for (int i = 0; i < 2; i++) begin
         tick();
         n_chk++;
         if (state !== 2'd0 || ctl !== 5'b00000) begin
            n_fail++;
            $display("FAIL x0_no_stall: state=%0d ctl=%b want 0 00000", state, ctl);
         end
      end
      idle();
   endtask

   task automatic test_mem_wait_branch();
      idle();
      for (int i = 0; i < 4; i++) begin
         mem_busy = 1;
         branch_taken = (i == 1);
         tick();
         n_chk++;
         if (state !== 2'd3 || id_ex_busy !== 1'b1 || ctl !== 5'b11010) begin
            n_fail++;
            $display("FAIL mem_wait_%0d: state=%0d ctl=%b want 3 11010",
                     i, state, ctl);
         end
      end
      idle();
      for (int i = 0; i < 3; i++) begin
         tick();
         n_chk++;
         if (state !== ((i < 2) ? 2'd2 : 2'd0)) begin
            n_fail++;
            $display("FAIL mem_pend_flush_%0d: state=%0d want %0d",
                     i, state, (i < 2) ? 2 : 0);
         end
      end
   endtask

   task automatic test_branch_vs_load();
      idle();
      branch_taken = 1; ex_load = 1; ex_rd = 5'd4; id_rs1 = 5'd4;
      tick();
      idle();
      n_chk++;
      if (state !== 2'd2) begin
         n_fail++;
         $display("FAIL branch_priority: state=%0d want 2", state);
      end
      seen_ls = 0;
      for (int i = 0; i < 2; i++) begin
         tick();
         if (state == 2'd1) seen_ls = 1;
      end
      n_chk++;
      if (seen_ls || state !== 2'd0) begin
         n_fail++;
         $display("FAIL branch_no_ls: state=%0d seen_ls=%0d want 0 0", state, seen_ls);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         rst          = ($urandom_range(0, 99) == 0);
         branch_taken = ($urandom_range(0, 7) == 0);
         mem_busy     = ($urandom_range(0, 3) == 0);
         ex_load      = $urandom_range(0, 1);
         ex_rd        = 5'($urandom_range(0, 3));
         id_rs1       = 5'($urandom_range(0, 3));
         id_rs2       = 5'($urandom_range(0, 3));
         tick();
         n_chk++;
         if (state !== 2'(m_mode) || ctl !== exp_ctl(m_mode) ||
             stall_cnt !== 16'(m_sc)) begin
            n_fail++;
            $display("FAIL random_%0d: state=%0d ctl=%b cnt=%0d want %0d %b %0d",
                     i, state, ctl, stall_cnt, m_mode, exp_ctl(m_mode), m_sc);
         end
         n_chk++;
         if ((id_ex_flush & id_ex_busy) !== 1'b0 ||
             (if_id_hold & if_id_flush) !== 1'b0) begin
            n_fail++;
            $display("FAIL exclusive_%0d: ctl=%b", i, ctl);
         end
      end
      idle();
   endtask

   task automatic test_saturation();
      idle();
      rst = 1;
      tick();
      rst = 0;
      mem_busy = 1;
      for (int i = 0; i < 70000; i++) tick();
      n_chk++;
      if (stall_cnt !== 16'hFFFF || state !== 2'd3 || m_sc != 65535) begin
         n_fail++;
         $display("FAIL stall_saturate: cnt=%h state=%0d want ffff 3", stall_cnt, state);
      end
      rst = 1;
      tick();
      n_chk++;
      if (stall_cnt !== 16'd0 || state !== 2'd2) begin
         n_fail++;
         $display("FAIL stall_reset: cnt=%h state=%0d want 0 2", stall_cnt, state);
      end
      idle();
   endtask

   initial begin
      idle();
      m_mode = FL; m_rem = FC; m_pend = 0; m_sc = 0;
      test_reset();
      test_load_use();
      test_x0();
      test_mem_wait_branch();
      test_branch_vs_load();
      test_random();
      test_saturation();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
